// File: rtl/pc_gen_btb.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit direction counters.
// Redirects on EX mispredicts; a trap redirect takes priority over everything.
module pc_gen_btb #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            ex_valid,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            flush_o
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_q [BTB_ENTRIES];
    logic [1:0]       ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             taken_eff, mispredict;
    logic             wr_en;
    logic [XLEN-1:0]  wr_target;
    logic [1:0]       wr_ctr;

    // Fetch-side lookup reads registered contents, so a same-cycle write is not visible.
    assign f_idx         = pc_q[IDX_W+1:2];
    assign f_tag         = pc_q[XLEN-1:IDX_W+2];
    assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_o  = f_hit && ctr_q[f_idx][1];
    assign pred_target_o = pred_taken_o ? target_q[f_idx] : pc_q + XLEN'(4);
    assign pc_o          = pc_q;

    assign taken_eff  = ex_is_jump | ex_taken;
    assign mispredict = ex_valid && ((taken_eff != ex_pred_taken) ||
                                     (taken_eff && (ex_target != ex_pred_target)));
    assign flush_o    = mispredict;

    assign e_idx = ex_pc[IDX_W+1:2];
    assign e_tag = ex_pc[XLEN-1:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    always_comb begin
        pc_d = pc_q;
        if (trap_i) begin
            pc_d = trap_vec_i;
        end else if (mispredict) begin
            pc_d = taken_eff ? ex_target : ex_pc + XLEN'(4);
        end else if (fetch_en) begin
            pc_d = pred_target_o;
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_target = target_q[e_idx];
        wr_ctr    = ctr_q[e_idx];
        if (ex_valid) begin
            if (e_hit) begin
                wr_en = 1'b1;
                if (ex_is_jump) begin
                    wr_ctr    = 2'b11;
                    wr_target = ex_target;
                end else if (ex_taken) begin
                    wr_ctr    = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
                    wr_target = ex_target;
                end else begin
                    wr_ctr    = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
                end
            end else if (taken_eff) begin
                // Miss on a taken transfer replaces whatever occupies the slot.
                wr_en     = 1'b1;
                wr_target = ex_target;
                wr_ctr    = ex_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[e_idx]  <= 1'b1;
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= wr_target;
            ctr_q[e_idx]    <= wr_ctr;
        end
    end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Bench for pc_gen_btb: directed walk through the fetch/redirect/BTB scenarios,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_gen_btb;
    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en, trap_i, ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] trap_vec_i, ex_pc, ex_target, ex_pred_target;
    logic [31:0] pc_o, pred_target_o;
    logic        pred_taken_o, flush_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: fetch PC plus a 16-slot table keyed by (pc/4)%16.
    logic [31:0] m_pc;
    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];

    logic [31:0] pool [8] = '{32'h100, 32'h104, 32'h10C, 32'h4C, 32'h40C, 32'h20, 32'h800, 32'h13C};

    pc_gen_btb #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
    endtask

    // Compare process: predicts this cycle's outputs, then advances the model.
    always @(negedge clk) begin : cmp
        int i, j;
        bit hit, e_hit, e_pt, teff, e_mis;
        logic [31:0] e_ptgt;
        if (chk_en) begin
            i      = int'((m_pc >> 2) % 16);
            hit    = m_valid[i] && (m_tag[i] == (m_pc >> 6));
            e_pt   = hit && (m_ctr[i] >= 2);
            e_ptgt = e_pt ? m_target[i] : m_pc + 32'd4;
            teff   = ex_is_jump || ex_taken;
            e_mis  = ex_valid && ((teff != ex_pred_taken) || (teff && ex_target != ex_pred_target));
            check("pc_o", pc_o, m_pc);
            check("pred_taken_o", {31'b0, pred_taken_o}, {31'b0, e_pt});
            check("pred_target_o", pred_target_o, e_ptgt);
            check("flush_o", {31'b0, flush_o}, {31'b0, e_mis});
            if (trap_i)        m_pc = trap_vec_i;
            else if (e_mis)    m_pc = teff ? ex_target : ex_pc + 32'd4;
            else if (fetch_en) m_pc = e_ptgt;
            if (ex_valid) begin
                j     = int'((ex_pc >> 2) % 16);
                e_hit = m_valid[j] && (m_tag[j] == (ex_pc >> 6));
                if (e_hit) begin
                    if (ex_is_jump) begin
                        m_ctr[j] = 3; m_target[j] = ex_target;
                    end else if (ex_taken) begin
                        m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3; m_target[j] = ex_target;
                    end else begin
                        m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                    end
                end else if (teff) begin
                    m_valid[j] = 1; m_tag[j] = ex_pc >> 6; m_target[j] = ex_target;
                    m_ctr[j] = ex_is_jump ? 3 : 2;
                end
            end
        end
    end

    task automatic begin_cyc(input bit fe);
        @(posedge clk);
        #1;
        fetch_en = fe; trap_i = 0; trap_vec_i = 0; ex_valid = 0; ex_is_jump = 0;
        ex_taken = 0; ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    task automatic end_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_trap(input logic [31:0] vec);
        trap_i = 1; trap_vec_i = vec;
    endtask

    task automatic set_ex(input bit jmp, input bit tk, input logic [31:0] pc, input logic [31:0] tgt,
                          input bit ptk, input logic [31:0] ptgt);
        ex_valid = 1; ex_is_jump = jmp; ex_taken = tk; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 1023)) << 2;
    endfunction

    task automatic random_cycle();
        logic [31:0] tgt;
        begin_cyc($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) set_trap(rand_addr());
        if ($urandom_range(0, 1) == 1) begin
            tgt = rand_addr();
            set_ex($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 1) == 1) ? m_pc : pool[$urandom_range(0, 7)], tgt,
                   $urandom_range(0, 1) == 1, ($urandom_range(0, 2) != 0) ? tgt : rand_addr());
        end
        end_cyc();
    endtask

    initial begin
        rst_n = 0; fetch_en = 0; trap_i = 0; trap_vec_i = 0; ex_valid = 0; ex_is_jump = 0;
        ex_taken = 0; ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        chk_en = 1;
        end_cyc();
        check("rst pc", pc_o, 32'h100);
        check("rst pred_taken", {31'b0, pred_taken_o}, 32'd0);
        check("rst pred_target", pred_target_o, 32'h104);
        check("rst flush", {31'b0, flush_o}, 32'd0);

        // Sequential fetch with a two-cycle stall at 0x108.
        begin_cyc(1); end_cyc(); check("seq pc0", pc_o, 32'h100);
        begin_cyc(1); end_cyc(); check("seq pc1", pc_o, 32'h104);
        begin_cyc(0); end_cyc(); check("seq pc2", pc_o, 32'h108);
        begin_cyc(0); end_cyc(); check("stall hold", pc_o, 32'h108);
        begin_cyc(1); end_cyc(); check("stall hold2", pc_o, 32'h108);
        check("seq no pred", {31'b0, pred_taken_o}, 32'd0);

        // Branch at 0x10C taken to 0x200 while predicted not-taken.
        begin_cyc(1); set_ex(0, 1, 32'h10C, 32'h200, 0, 32'h110); end_cyc();
        check("seq pc3", pc_o, 32'h10C);
        check("br flush", {31'b0, flush_o}, 32'd1);
        begin_cyc(0); end_cyc(); check("br redirect", pc_o, 32'h200);
        begin_cyc(0); set_trap(32'h10C); end_cyc();
        begin_cyc(0); end_cyc();
        check("br refetch pc", pc_o, 32'h10C);
        check("br pred_taken", {31'b0, pred_taken_o}, 32'd1);
        check("br pred_target", pred_target_o, 32'h200);

        // Two not-taken resolutions: 10 -> 01 -> 00.
        begin_cyc(0); set_ex(0, 0, 32'h10C, 32'h200, 1, 32'h200); end_cyc();
        check("nt flush", {31'b0, flush_o}, 32'd1);
        begin_cyc(0); end_cyc(); check("nt redirect", pc_o, 32'h110);
        begin_cyc(0); set_ex(0, 0, 32'h10C, 32'h200, 0, 32'h110); set_trap(32'h10C); end_cyc();
        check("nt2 no flush", {31'b0, flush_o}, 32'd0);
        begin_cyc(0); end_cyc();
        check("nt pred_taken", {31'b0, pred_taken_o}, 32'd0);
        check("nt pred_target", pred_target_o, 32'h110);

        // Four taken (00 -> 11, saturating) then one not-taken leaves 10.
        repeat (4) begin
            begin_cyc(0); set_ex(0, 1, 32'h10C, 32'h200, 1, 32'h200); end_cyc();
        end
        begin_cyc(0); set_ex(0, 0, 32'h10C, 32'h200, 0, 32'h110); set_trap(32'h10C); end_cyc();
        begin_cyc(0); end_cyc();
        check("sat pred_taken", {31'b0, pred_taken_o}, 32'd1);

        // Aliasing: 0x4C and 0x40C share slot 3.
        begin_cyc(0); set_ex(1, 1, 32'h4C, 32'h300, 0, 32'h50); end_cyc();
        check("jal flush", {31'b0, flush_o}, 32'd1);
        begin_cyc(0); end_cyc(); check("jal redirect", pc_o, 32'h300);
        begin_cyc(0); set_trap(32'h40C); end_cyc();
        begin_cyc(0); end_cyc();
        check("alias miss", {31'b0, pred_taken_o}, 32'd0);
        check("alias target", pred_target_o, 32'h410);
        begin_cyc(0); set_trap(32'h4C); end_cyc();
        begin_cyc(0); end_cyc();
        check("jal hit", {31'b0, pred_taken_o}, 32'd1);
        check("jal target", pred_target_o, 32'h300);
        begin_cyc(0); set_ex(0, 1, 32'h40C, 32'h500, 0, 32'h410); set_trap(32'h4C); end_cyc();
        begin_cyc(0); end_cyc();
        check("evicted miss", {31'b0, pred_taken_o}, 32'd0);
        check("evicted target", pred_target_o, 32'h50);

        // Trap and mispredict together while stalled.
        begin_cyc(0); set_ex(1, 1, 32'h20, 32'h600, 0, 32'h24); set_trap(32'h80); end_cyc();
        check("trap+mis flush", {31'b0, flush_o}, 32'd1);
        begin_cyc(0); end_cyc(); check("trap wins", pc_o, 32'h80);
        begin_cyc(0); set_trap(32'h20); end_cyc();
        begin_cyc(0); end_cyc();
        check("trap btb upd", {31'b0, pred_taken_o}, 32'd1);
        check("trap btb tgt", pred_target_o, 32'h600);

        // Sequential wrap at the top of the address space.
        begin_cyc(0); set_trap(32'hFFFF_FFFC); end_cyc();
        begin_cyc(1); end_cyc();
        check("wrap tgt", pred_target_o, 32'h0);
        begin_cyc(1); end_cyc(); check("wrap pc", pc_o, 32'h0);

        repeat (600) random_cycle();

        // Asynchronous reset in the middle of a cycle.
        begin_cyc(0);
        #2;
        chk_en = 0;
        rst_n  = 0;
        #1;
        check("async rst pc", pc_o, RV);
        check("async rst pred", {31'b0, pred_taken_o}, 32'd0);
        check("async rst tgt", pred_target_o, RV + 32'd4);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        chk_en = 1;
        repeat (200) random_cycle();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_btb.md
# pc_gen_btb

Parametrised fetch-address generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It holds the fetch PC and predicts the next fetch address from the BTB. Execute-stage resolution is checked against the prediction that travelled with the instruction; on a mispredict it redirects and flushes. A trap redirect overrides everything. It sits between the IF stage and the EX branch-resolution logic.

## Interface
- XLEN, 32, address/data width (≥16)
- RESET_VECTOR, 0, PC value after reset (word aligned)
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES), TAG_W = XLEN-2-IDX_W

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_en  in  1  1 = IF may advance; 0 = hold pc_o (stall)
- trap_i  in  1  trap/exception redirect request
- trap_vec_i  in  XLEN  trap target address
- ex_valid  in  1  EX holds a resolved control-flow instruction this cycle
- ex_is_jump  in  1  instruction is JAL/JALR (always taken)
- ex_taken  in  1  resolved direction (ignored when ex_is_jump=1; treated as 1)
- ex_pc  in  XLEN  PC of the resolving instruction
- ex_target  in  XLEN  resolved target address
- ex_pred_taken  in  1  pred_taken_o that accompanied this instruction
- ex_pred_target  in  XLEN  pred_target_o that accompanied this instruction
- pc_o  out  XLEN  current fetch PC (registered)
- pred_taken_o  out  1  prediction for instruction at pc_o
- pred_target_o  out  XLEN  predicted next PC for instruction at pc_o
- flush_o  out  1  mispredict detected this cycle; IF/ID and ID/EX must squash

## Operation
- BTB entry: valid, tag[TAG_W], target[XLEN], ctr[2]. idx = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational on pc_o): hit = valid[idx] && tag match. pred_taken_o = hit && ctr[1]. pred_target_o = pred_taken_o ? target : pc_o+4 (mod 2^XLEN, wraps).
- taken_eff = ex_is_jump | ex_taken. mispredict = ex_valid && (taken_eff != ex_pred_taken || (taken_eff && ex_target != ex_pred_target)). flush_o = mispredict.
- Next PC priority: trap_i → trap_vec_i; else mispredict → (taken_eff ? ex_target : ex_pc+4); else fetch_en → pred_target_o; else hold. Redirects apply even when fetch_en=0.
- BTB update whenever ex_valid=1, indexed by ex_pc:
  - Hit + jump: ctr←11, target←ex_target.
  - Hit + branch taken: ctr←sat_inc, target←ex_target.
  - Hit + branch not taken: ctr←sat_dec; target unchanged.
  - Miss + taken_eff: allocate/replace: valid←1, tag, target←ex_target, ctr←11 for jump, 10 for branch.
  - Miss + not taken: no change.
- Saturation: 11 stays 11 on increment; 00 stays 00 on decrement.
- trap_i does not suppress the BTB update from a concurrent ex_valid.

## Timing
- Reset (asynchronous): pc_o=RESET_VECTOR, all valid=0, all ctr=01, all tag/target=0. Outputs after reset: pred_taken_o=0, pred_target_o=RESET_VECTOR+4, flush_o=0.
- pc_o updates on posedge clk. Redirect/trap latency: the request cycle → new pc_o on the next edge (1 cycle).
- pred_* and flush_o are combinational, valid in the same cycle as their inputs.
- BTB writes land at posedge. A lookup in the same cycle as a write to the same idx sees the old contents; the new contents are visible from the next cycle.
- Reset asserted mid-operation clears state immediately, regardless of clk.
- Simultaneous trap_i and mispredict: pc_o←trap_vec_i and flush_o=1.

## Test plan
- Reset, RESET_VECTOR=32'h100, fetch_en=1 for 3 cycles → pc_o 100,104,108,10C; pred_taken_o=0 throughout.
- fetch_en=0 for 2 cycles at pc_o=0x108 → pc_o holds 0x108. Release fetch_en → 0x10C.
- Branch at 0x10C resolves taken to 0x200 with pred_taken=0 → flush_o=1, next pc_o=0x200. Entry idx 3 gets ctr=10. On the next fetch of 0x10C: pred_taken_o=1, pred_target_o=0x200.
- Same branch resolves not-taken twice after the previous step → ctr 10→01→00. On the first not-taken, with pred_taken=1: flush_o=1, pc_o←0x110. Afterwards pred_taken_o=0 at 0x10C. A taken resolution at ctr=11 stays 11.
- Aliasing, BTB_ENTRIES=16: JAL at 0x4C to 0x300 installed, then 0x40C (same idx, different tag) looked up → hit=0, pred_target_o=0x410. A taken resolve at 0x40C replaces the entry, and 0x4C then misses.
- Same cycle: trap_i=1 (vec 0x80) with a mispredicting ex_valid at stall (fetch_en=0) → flush_o=1, next pc_o=0x80, BTB still updated. Separately, pc_o=0xFFFFFFFC with fetch_en=1 and no hit → pc_o wraps to 0x0.
